wb_uart_dbg_master: RTL and testbench

//  UART-driven Wishbone master for host debug and memory load. It decodes 8N1 command frames on

---
 rtl/wb_uart_dbg_master_if.sv | 25 ++
 rtl/wb_uart_dbg_master.sv | 232 +++++++++++++++++++++++
 tb/tb_wb_uart_dbg_master.sv | 231 +++++++++++++++++++++++
 3 files changed

// File: rtl/wb_uart_dbg_master_if.sv
// Classic Wishbone master bundle used by the UART debug master.
// dat_w carries master write data and dat_r carries slave read data.
interface wb_uart_dbg_master_if;
  logic [31:0] adr;
  logic [31:0] dat_w;
  logic [31:0] dat_r;
  logic [3:0]  sel;
  logic        we;
  logic        cyc;
  logic        stb;
  logic [2:0]  cti;
  logic [1:0]  bte;
  logic        ack;
  logic        err;

  modport master (
    output adr, dat_w, sel, we, cyc, stb, cti, bte,
    input  dat_r, ack, err
  );

  modport slave (
    input  adr, dat_w, sel, we, cyc, stb, cti, bte,
    output dat_r, ack, err
  );
endinterface

// File: rtl/wb_uart_dbg_master.sv
// UART (8N1) command decoder that issues single classic Wishbone read/write cycles
// and answers with 'K' (+ read data) or 'E' on the serial output.
module wb_uart_dbg_master #(
  parameter int unsigned CLKS_PER_BIT = 868,
  parameter int unsigned TIMEOUT      = 1023
) (
  input  logic                        wb_clk_i,
  input  logic                        wb_rst_n_i,
  input  logic                        uart_rx_i,
  output logic                        uart_tx_o,
  output logic                        busy_o,
  wb_uart_dbg_master_if.master        wbm
);

  localparam int unsigned CntW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int unsigned ToW  = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CntW-1:0] BitLast  = CntW'(CLKS_PER_BIT - 1);
  localparam logic [CntW-1:0] HalfLast = CntW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [ToW-1:0]  ToMax    = ToW'(TIMEOUT);

  typedef enum logic [1:0] {RxIdle, RxStart, RxData, RxStop} rx_state_e;
  typedef enum logic [2:0] {StIdle, StAddr, StData, StBus, StResp} state_e;

  // RX synchronizer and deserializer
  logic            r_rx_meta, r_rx_sync, r_rx_prev;
  rx_state_e       r_rx_state, w_rx_state_d;
  logic [CntW-1:0] r_rx_cnt, w_rx_cnt_d;
  logic [2:0]      r_rx_bit, w_rx_bit_d;
  logic [7:0]      r_rx_shift, w_rx_shift_d;
  logic            w_rx_fall, w_rx_done, w_rx_ferr;

  assign w_rx_fall = r_rx_prev & ~r_rx_sync;

  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      r_rx_meta  <= 1'b1;
      r_rx_sync  <= 1'b1;
      r_rx_prev  <= 1'b1;
      r_rx_state <= RxIdle;
      r_rx_cnt   <= '0;
      r_rx_bit   <= '0;
      r_rx_shift <= '0;
    end else begin
      r_rx_meta  <= uart_rx_i;
      r_rx_sync  <= r_rx_meta;
      r_rx_prev  <= r_rx_sync;
      r_rx_state <= w_rx_state_d;
      r_rx_cnt   <= w_rx_cnt_d;
      r_rx_bit   <= w_rx_bit_d;
      r_rx_shift <= w_rx_shift_d;
    end
  end

  always_comb begin
    w_rx_state_d = r_rx_state;
    w_rx_cnt_d   = r_rx_cnt + 1'b1;
    w_rx_bit_d   = r_rx_bit;
    w_rx_shift_d = r_rx_shift;
    w_rx_done    = 1'b0;
    w_rx_ferr    = 1'b0;
    case (r_rx_state)
      RxIdle: begin
        w_rx_cnt_d = '0;
        if (w_rx_fall) w_rx_state_d = RxStart;
      end
      RxStart: begin
        if (r_rx_cnt == HalfLast) begin
          w_rx_cnt_d   = '0;
          w_rx_bit_d   = '0;
          // A start bit that is high again at mid-bit was only a glitch
          w_rx_state_d = r_rx_sync ? RxIdle : RxData;
        end
      end
      RxData: begin
        if (r_rx_cnt == BitLast) begin
          w_rx_cnt_d   = '0;
          w_rx_shift_d = {r_rx_sync, r_rx_shift[7:1]};
          w_rx_bit_d   = r_rx_bit + 1'b1;
          if (r_rx_bit == 3'd7) w_rx_state_d = RxStop;
        end
      end
      RxStop: begin
        if (r_rx_cnt == BitLast) begin
          w_rx_state_d = RxIdle;
          w_rx_done    = r_rx_sync;
          w_rx_ferr    = ~r_rx_sync;
        end
      end
      default: w_rx_state_d = RxIdle;
    endcase
  end

  // Command FSM, bus cycle and response serializer
  state_e          r_state, w_state_d;
  logic            r_is_write, w_is_write_d;
  logic [1:0]      r_byte_cnt, w_byte_cnt_d;
  logic [31:0]     r_addr, w_addr_d;
  logic [31:0]     r_wdata, w_wdata_d;
  logic [31:0]     r_rdata, w_rdata_d;
  logic [ToW-1:0]  r_to_cnt, w_to_cnt_d, w_to_next;
  logic [2:0]      r_resp_left, w_resp_left_d;
  logic [9:0]      r_tx_shift, w_tx_shift_d;
  logic [CntW-1:0] r_tx_cnt, w_tx_cnt_d;
  logic [3:0]      r_tx_bit, w_tx_bit_d;
  logic            w_bus_end, w_bus_ok;

  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      r_state     <= StIdle;
      r_is_write  <= 1'b0;
      r_byte_cnt  <= '0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_rdata     <= '0;
      r_to_cnt    <= '0;
      r_resp_left <= '0;
      r_tx_shift  <= '1;
      r_tx_cnt    <= '0;
      r_tx_bit    <= '0;
    end else begin
      r_state     <= w_state_d;
      r_is_write  <= w_is_write_d;
      r_byte_cnt  <= w_byte_cnt_d;
      r_addr      <= w_addr_d;
      r_wdata     <= w_wdata_d;
      r_rdata     <= w_rdata_d;
      r_to_cnt    <= w_to_cnt_d;
      r_resp_left <= w_resp_left_d;
      r_tx_shift  <= w_tx_shift_d;
      r_tx_cnt    <= w_tx_cnt_d;
      r_tx_bit    <= w_tx_bit_d;
    end
  end

  assign w_to_next = r_to_cnt + 1'b1;

  always_comb begin
    w_state_d     = r_state;
    w_is_write_d  = r_is_write;
    w_byte_cnt_d  = r_byte_cnt;
    w_addr_d      = r_addr;
    w_wdata_d     = r_wdata;
    w_rdata_d     = r_rdata;
    w_to_cnt_d    = r_to_cnt;
    w_resp_left_d = r_resp_left;
    w_tx_shift_d  = r_tx_shift;
    w_tx_cnt_d    = r_tx_cnt;
    w_tx_bit_d    = r_tx_bit;
    w_bus_end     = 1'b0;
    w_bus_ok      = 1'b0;
    case (r_state)
      StIdle: begin
        w_byte_cnt_d = '0;
        if (w_rx_done && (r_rx_shift == 8'h52 || r_rx_shift == 8'h57)) begin
          w_is_write_d = (r_rx_shift == 8'h57);
          w_state_d    = StAddr;
        end
      end
      StAddr: begin
        if (w_rx_ferr) begin
          w_state_d = StIdle;
        end else if (w_rx_done) begin
          w_addr_d     = {r_addr[23:0], r_rx_shift};
          w_byte_cnt_d = r_byte_cnt + 1'b1;
          w_to_cnt_d   = '0;
          if (r_byte_cnt == 2'd3) w_state_d = r_is_write ? StData : StBus;
        end
      end
      StData: begin
        if (w_rx_ferr) begin
          w_state_d = StIdle;
        end else if (w_rx_done) begin
          w_wdata_d    = {r_wdata[23:0], r_rx_shift};
          w_byte_cnt_d = r_byte_cnt + 1'b1;
          w_to_cnt_d   = '0;
          if (r_byte_cnt == 2'd3) w_state_d = StBus;
        end
      end
      StBus: begin
        // Counter stops at TIMEOUT because the cycle ends on that edge
        if (TIMEOUT != 0) w_to_cnt_d = w_to_next;
        if (wbm.err) begin
          w_bus_end = 1'b1;
        end else if (wbm.ack) begin
          w_bus_end = 1'b1;
          w_bus_ok  = 1'b1;
          w_rdata_d = wbm.dat_r;
        end else if (TIMEOUT != 0 && w_to_next == ToMax) begin
          w_bus_end = 1'b1;
        end
        if (w_bus_end) begin
          w_state_d     = StResp;
          w_tx_shift_d  = {1'b1, (w_bus_ok ? 8'h4B : 8'h45), 1'b0};
          w_tx_cnt_d    = '0;
          w_tx_bit_d    = '0;
          w_resp_left_d = (w_bus_ok && !r_is_write) ? 3'd4 : 3'd0;
        end
      end
      StResp: begin
        w_tx_cnt_d = r_tx_cnt + 1'b1;
        if (r_tx_cnt == BitLast) begin
          w_tx_cnt_d   = '0;
          w_tx_shift_d = {1'b1, r_tx_shift[9:1]};
          w_tx_bit_d   = r_tx_bit + 1'b1;
          if (r_tx_bit == 4'd9) begin
            w_tx_bit_d = '0;
            if (r_resp_left != 3'd0) begin
              w_tx_shift_d  = {1'b1, r_rdata[31:24], 1'b0};
              w_rdata_d     = {r_rdata[23:0], 8'h00};
              w_resp_left_d = r_resp_left - 1'b1;
            end else begin
              w_state_d = StIdle;
            end
          end
        end
      end
      default: w_state_d = StIdle;
    endcase
  end

  assign uart_tx_o = r_tx_shift[0];
  assign busy_o    = (r_state != StIdle);
  assign wbm.cyc   = (r_state == StBus);
  assign wbm.stb   = wbm.cyc;
  assign wbm.sel   = wbm.cyc ? 4'hF : 4'h0;
  assign wbm.we    = wbm.cyc & r_is_write;
  assign wbm.adr   = r_addr;
  assign wbm.dat_w = r_wdata;
  assign wbm.cti   = 3'b000;
  assign wbm.bte   = 2'b00;

endmodule

// File: tb/tb_wb_uart_dbg_master.sv
// Self-checking bench: table vectors, random transactions against a response model,
// plus framing, reset and overrun sequences.
module tb_wb_uart_dbg_master;
  localparam int CPB = 4;
  localparam int TO  = 16;
  localparam int MAck = 0, MErr = 1, MNone = 2, MBoth = 3;

  typedef struct {
    bit          is_w;
    logic [31:0] adr;
    logic [31:0] wd;
    logic [31:0] rd;
    int          mode;
    int          delay;
    int          exp_len;
    int          exp_n;
    logic [39:0] exp_b;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic rx = 1'b1;
  logic tx, busy;
  wb_uart_dbg_master_if bus();

  wb_uart_dbg_master #(.CLKS_PER_BIT(CPB), .TIMEOUT(TO)) dut (
    .wb_clk_i   (clk),
    .wb_rst_n_i (rst_n),
    .uart_rx_i  (rx),
    .uart_tx_o  (tx),
    .busy_o     (busy),
    .wbm        (bus.master)
  );

  always #5 clk = ~clk;

  int n_cmp = 0, n_fail = 0;
  int s_mode = MAck, s_delay = 1;
  logic [31:0] s_rdata = '0;
  int cyc_cnt = 0, last_len = 0, n_cycles = 0, tx_stop_err = 0;
  logic [31:0] cap_adr, cap_dat;
  logic cap_we, cap_stb;
  logic [3:0] cap_sel;
  logic [7:0] txq[$];
  logic [7:0] mon_b;
  vec_t tbl[8];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Wishbone slave: responds on the s_delay-th cycle of cyc, captures the request
  initial begin
    bus.ack = 1'b0; bus.err = 1'b0; bus.dat_r = '0;
    forever begin
      @(posedge clk); #1;
      bus.ack = 1'b0; bus.err = 1'b0; bus.dat_r = ~s_rdata;
      if (bus.cyc === 1'b1) begin
        if (cyc_cnt == 0) begin
          cap_adr = bus.adr; cap_dat = bus.dat_w; cap_we = bus.we;
          cap_sel = bus.sel; cap_stb = bus.stb; n_cycles++;
        end
        cyc_cnt++;
        if (cyc_cnt == s_delay) begin
          if (s_mode == MAck || s_mode == MBoth) begin bus.ack = 1'b1; bus.dat_r = s_rdata; end
          if (s_mode == MErr || s_mode == MBoth) bus.err = 1'b1;
        end
      end else if (cyc_cnt != 0) begin
        last_len = cyc_cnt;
        cyc_cnt  = 0;
      end
    end
  end

  // UART receiver on uart_tx_o
  initial forever begin
    @(negedge clk);
    if (rst_n === 1'b1 && tx === 1'b0) begin
      repeat (CPB / 2) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
        repeat (CPB) @(negedge clk);
        mon_b[i] = tx;
      end
      repeat (CPB) @(negedge clk);
      if (tx !== 1'b1) tx_stop_err++;
      txq.push_back(mon_b);
    end
  end

  task automatic send_byte(input logic [7:0] b, input logic stop);
    logic [9:0] f;
    f = {stop, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      rx = f[i];
      repeat (CPB) @(posedge clk); #1;
    end
  endtask

  task automatic send_frame(input bit is_w, input logic [31:0] adr, input logic [31:0] wd);
    send_byte(is_w ? 8'h57 : 8'h52, 1'b1);
    for (int i = 3; i >= 0; i--) send_byte(adr[8*i +: 8], 1'b1);
    if (is_w) for (int i = 3; i >= 0; i--) send_byte(wd[8*i +: 8], 1'b1);
  endtask

  // Reference: outcome decided by which comes first, the slave event or the timeout
  function automatic vec_t model(input bit is_w, input logic [31:0] adr, input logic [31:0] wd,
                                 input logic [31:0] rd, input int mode, input int delay);
    vec_t v;
    bit ok;
    v.is_w = is_w; v.adr = adr; v.wd = wd; v.rd = rd; v.mode = mode; v.delay = delay;
    if (mode != MNone && delay <= TO) begin
      v.exp_len = delay;
      ok = (mode == MAck);
    end else begin
      v.exp_len = TO;
      ok = 1'b0;
    end
    if (!ok)       begin v.exp_n = 1; v.exp_b = {8'h45, 32'h0}; end
    else if (is_w) begin v.exp_n = 1; v.exp_b = {8'h4B, 32'h0}; end
    else           begin v.exp_n = 5; v.exp_b = {8'h4B, rd};    end
    return v;
  endfunction

  task automatic run_txn(input vec_t v, input int n_junk);
    int n0, i;
    s_mode = v.mode; s_delay = v.delay; s_rdata = v.rd;
    txq.delete();
    n0 = n_cycles;
    send_frame(v.is_w, v.adr, v.wd);
    chk("busy_set", busy, 1'b1);
    if (n_junk > 0) begin
      for (i = 0; i < 200 && tx !== 1'b0; i++) @(posedge clk);
      #1;
      for (int j = 0; j < n_junk; j++) send_byte(8'($urandom), 1'b1);
    end
    for (i = 0; i < 3000 && txq.size() < v.exp_n; i++) @(negedge clk);
    if (txq.size() < v.exp_n) chk("resp_wait", txq.size(), v.exp_n);
    else chk("busy_in_last_stop", busy, 1'b1);
    for (i = 0; i < 100 && busy !== 1'b0; i++) @(negedge clk);
    chk("busy_fall", busy, 1'b0);
    chk("n_bus_cycles", n_cycles - n0, 1);
    chk("adr", cap_adr, v.adr);
    chk("we", cap_we, v.is_w);
    chk("sel", cap_sel, 4'hF);
    chk("stb", cap_stb, 1'b1);
    if (v.is_w) chk("dat_o", cap_dat, v.wd);
    chk("cyc_len", last_len, v.exp_len);
    chk("resp_n", txq.size(), v.exp_n);
    for (int k = 0; k < v.exp_n && k < txq.size(); k++)
      chk($sformatf("resp_b%0d", k), txq[k], v.exp_b[39-8*k -: 8]);
    chk("tx_idle", tx, 1'b1);
  endtask

  initial begin
    int n0, i;
    vec_t v;
    tbl[0] = '{1'b1, 32'h0000_1000, 32'hDEAD_BEEF, 32'h0,         MAck,  2,  2,  1, {8'h4B, 32'h0}};
    tbl[1] = '{1'b0, 32'h0000_1000, 32'h0,         32'h1234_5678, MAck,  2,  2,  5, {8'h4B, 32'h1234_5678}};
    tbl[2] = '{1'b0, 32'h0000_2000, 32'h0,         32'h0,         MNone, 1,  16, 1, {8'h45, 32'h0}};
    tbl[3] = '{1'b1, 32'h0000_3000, 32'hCAFE_F00D, 32'h0,         MBoth, 3,  3,  1, {8'h45, 32'h0}};
    tbl[4] = '{1'b0, 32'h0000_4000, 32'h0,         32'hA5A5_5A5A, MAck,  16, 16, 5, {8'h4B, 32'hA5A5_5A5A}};
    tbl[5] = '{1'b0, 32'h0000_4004, 32'h0,         32'h1111_2222, MAck,  17, 16, 1, {8'h45, 32'h0}};
    tbl[6] = '{1'b1, 32'hFFFF_FFFC, 32'h0102_0304, 32'h0,         MAck,  1,  1,  1, {8'h4B, 32'h0}};
    tbl[7] = '{1'b1, 32'h8000_0000, 32'h5555_AAAA, 32'h0,         MErr,  5,  5,  1, {8'h45, 32'h0}};

    repeat (3) @(posedge clk); #1;
    chk("rst_tx", tx, 1'b1);
    chk("rst_busy", busy, 1'b0);
    chk("rst_cyc", bus.cyc, 1'b0);
    chk("rst_sel", bus.sel, 4'h0);
    chk("rst_we", bus.we, 1'b0);
    chk("rst_adr", bus.adr, 32'h0);
    chk("rst_dat", bus.dat_w, 32'h0);
    rst_n = 1'b1;
    repeat (2) @(posedge clk); #1;
    chk("cti", bus.cti, 3'b000);
    chk("bte", bus.bte, 2'b00);

    for (int t = 0; t < 8; t++) run_txn(tbl[t], 0);

    // Junk command, aborted frame and a start glitch produce no bus activity
    n0 = n_cycles;
    txq.delete();
    send_byte(8'h41, 1'b1);
    send_byte(8'h57, 1'b1);
    send_byte(8'h00, 1'b0);
    rx = 1'b1;
    repeat (2 * CPB) @(posedge clk); #1;
    rx = 1'b0; @(posedge clk); #1; rx = 1'b1;
    repeat (3 * CPB) @(posedge clk); #1;
    chk("junk_busy", busy, 1'b0);
    chk("junk_cycles", n_cycles - n0, 0);
    chk("junk_resp", txq.size(), 0);
    run_txn(model(1'b0, 32'h0000_0040, 32'h0, 32'h8765_4321, MAck, 3), 0);

    // Reset in the middle of a bus cycle
    s_mode = MNone;
    send_frame(1'b0, 32'h0000_0500, 32'h0);
    for (i = 0; i < 50 && bus.cyc !== 1'b1; i++) @(posedge clk);
    chk("rst_mid_cyc_seen", bus.cyc, 1'b1);
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_mid_cyc", bus.cyc, 1'b0);
    chk("rst_mid_stb", bus.stb, 1'b0);
    chk("rst_mid_tx", tx, 1'b1);
    chk("rst_mid_busy", busy, 1'b0);
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (2) @(posedge clk); #1;
    run_txn(model(1'b0, 32'h0000_0600, 32'h0, 32'h0BAD_F00D, MAck, 2), 0);

    // Bytes sent during the response are dropped
    run_txn(model(1'b0, 32'h0000_0700, 32'h0, 32'hFEED_C0DE, MAck, 2), 3);
    run_txn(model(1'b1, 32'h0000_0704, 32'h1357_9BDF, 32'h0, MAck, 4), 0);

    for (int r = 0; r < 25; r++) begin
      v = model(1'($urandom), $urandom, $urandom, $urandom,
                int'($urandom_range(3, 0)), int'($urandom_range(20, 1)));
      run_txn(v, 0);
    end

    chk("tx_stop_bits", tx_stop_err, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
